// File: rtl/tca_histogram_mem.sv
// tca_histogram_mem: time-correlation histogram, one counter per delay bin.
// Hits are accumulated by a two-stage read-modify-write with forwarding.
// A clear sweep and a streamed readout run from a small FSM.
//
// Readout handshake: a beat transfers on a rising clk edge where out_valid and
// out_ready are both high. Once out_valid is raised, out_bin/out_count/out_last
// hold steady until that edge. out_ready may be low for any number of cycles.
module tca_histogram_mem #(
  parameter int BIN_W       = 8,
  parameter int CNT_W       = 16,
  parameter bit SATURATE    = 1'b1,
  parameter bit CLR_ON_READ = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hit_valid,
  input  logic [BIN_W-1:0] hit_bin,
  input  logic [1:0]       cmd,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIN_W-1:0] out_bin,
  output logic [CNT_W-1:0] out_count,
  output logic             out_last,
  output logic [15:0]      drop_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {ST_ACCUM, ST_DRAIN, ST_CLEAR, ST_READ} state_e;

  localparam logic [BIN_W-1:0] LAST_BIN = '1;
  localparam logic [BIN_W-1:0] BIN_ONE  = {{(BIN_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  state_e             target_q, target_d;
  logic               drain_q, drain_d;          // second DRAIN cycle
  logic [BIN_W-1:0]   addr_q, addr_d;            // clear sweep / read fetch address
  logic               fetch_done_q, fetch_done_d;
  logic               pf_valid_q, pf_valid_d;    // rd_q holds data of pf_bin_q
  logic [BIN_W-1:0]   pf_bin_q, pf_bin_d;
  logic               out_valid_q, out_valid_d;
  logic [BIN_W-1:0]   out_bin_q, out_bin_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_last_q, out_last_d;
  logic [15:0]        drop_q, drop_d;

  logic               s1_valid_q, s2_valid_q;
  logic [BIN_W-1:0]   s1_bin_q, s2_bin_q;
  logic [CNT_W-1:0]   s2_cnt_q;

  logic [CNT_W-1:0]   mem [0:(1<<BIN_W)-1];
  logic [CNT_W-1:0]   rd_q;
  logic [BIN_W-1:0]   raddr, waddr;
  logic [CNT_W-1:0]   wdata;
  logic               we;
  logic [CNT_W-1:0]   old_cnt, new_cnt;
  logic               accept, load;

  assign accept = out_valid_q && out_ready;
  assign load   = pf_valid_q && (!out_valid_q || accept);

  // Increment datapath: take the previous write when it hit the same bin,
  // since the RAM read for this bin was issued on the edge of that write.
  always_comb begin
    old_cnt = (s2_valid_q && (s2_bin_q == s1_bin_q)) ? s2_cnt_q : rd_q;
    new_cnt = (SATURATE && (old_cnt == CNT_MAX)) ? old_cnt : old_cnt + CNT_ONE;
  end

  // RAM port muxing: hits read at acceptance; readout re-reads a stalled prefetch.
  always_comb begin
    raddr = addr_q;
    if (state_q == ST_ACCUM)         raddr = hit_bin;
    else if (pf_valid_q && !load)    raddr = pf_bin_q;
    we    = 1'b0;
    waddr = s1_bin_q;
    wdata = new_cnt;
    if (s1_valid_q) begin
      we = 1'b1;
    end else if (state_q == ST_CLEAR) begin
      we    = 1'b1;
      waddr = addr_q;
      wdata = '0;
    end else if (CLR_ON_READ && (state_q == ST_READ) && accept) begin
      we    = 1'b1;
      waddr = out_bin_q;
      wdata = '0;
    end
  end

  // Counter storage: synchronous read, single write port, no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_q <= mem[raddr];
  end

  // Accumulate pipeline: S1 holds the accepted hit, S2 records the last write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_bin_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_bin_q   <= '0;
      s2_cnt_q   <= '0;
    end else begin
      s1_valid_q <= hit_valid && (state_q == ST_ACCUM);
      s1_bin_q   <= hit_bin;
      s2_valid_q <= s1_valid_q;
      s2_bin_q   <= s1_bin_q;
      s2_cnt_q   <= new_cnt;
    end
  end

  // Next-state logic for the control FSM, clear sweep and readout stream.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    drain_d      = drain_q;
    addr_d       = addr_q;
    fetch_done_d = fetch_done_q;
    pf_valid_d   = pf_valid_q;
    pf_bin_d     = pf_bin_q;
    out_valid_d  = out_valid_q;
    out_bin_d    = out_bin_q;
    out_count_d  = out_count_q;
    out_last_d   = out_last_q;
    drop_d       = drop_q;

    if (hit_valid && (state_q != ST_ACCUM) && (drop_q != 16'hFFFF))
      drop_d = drop_q + 16'd1;

    case (state_q)
      ST_ACCUM: begin
        addr_d       = '0;
        fetch_done_d = 1'b0;
        pf_valid_d   = 1'b0;
        drain_d      = 1'b0;
        if (cmd == 2'b01) begin
          state_d  = ST_DRAIN;
          target_d = ST_CLEAR;
        end else if (cmd == 2'b10) begin
          state_d  = ST_DRAIN;
          target_d = ST_READ;
        end
      end
      ST_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = target_q;
      end
      ST_CLEAR: begin
        addr_d = addr_q + BIN_ONE;
        if (addr_q == LAST_BIN) state_d = ST_ACCUM;
      end
      ST_READ: begin
        if (accept) out_valid_d = 1'b0;
        if (load) begin
          out_valid_d = 1'b1;
          out_bin_d   = pf_bin_q;
          out_count_d = rd_q;
          out_last_d  = (pf_bin_q == LAST_BIN);
          pf_valid_d  = 1'b0;
        end
        if ((!pf_valid_q || load) && !fetch_done_q) begin
          pf_valid_d = 1'b1;
          pf_bin_d   = addr_q;
          addr_d     = addr_q + BIN_ONE;
          if (addr_q == LAST_BIN) fetch_done_d = 1'b1;
        end
        if (accept && out_last_q) begin
          state_d     = ST_ACCUM;
          out_valid_d = 1'b0;
          out_bin_d   = '0;
          out_count_d = '0;
          out_last_d  = 1'b0;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // Control state register; reset aborts any sweep or readout at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ACCUM;
      target_q     <= ST_CLEAR;
      drain_q      <= 1'b0;
      addr_q       <= '0;
      fetch_done_q <= 1'b0;
      pf_valid_q   <= 1'b0;
      pf_bin_q     <= '0;
      out_valid_q  <= 1'b0;
      out_bin_q    <= '0;
      out_count_q  <= '0;
      out_last_q   <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      drain_q      <= drain_d;
      addr_q       <= addr_d;
      fetch_done_q <= fetch_done_d;
      pf_valid_q   <= pf_valid_d;
      pf_bin_q     <= pf_bin_d;
      out_valid_q  <= out_valid_d;
      out_bin_q    <= out_bin_d;
      out_count_q  <= out_count_d;
      out_last_q   <= out_last_d;
      drop_q       <= drop_d;
    end
  end

  assign busy      = (state_q != ST_ACCUM);
  assign out_valid = out_valid_q;
  assign out_bin   = out_bin_q;
  assign out_count = out_count_q;
  assign out_last  = out_last_q;
  assign drop_cnt  = drop_q;
  assign dbg_state = state_q;

endmodule
